// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between the I-cache and D-cache,
// alternating grants on contention so neither side can starve.
module cache_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);
   localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] ALIGN = {{(ADDR_WIDTH - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR} state_t;

   state_t                state, state_d;
   logic                  last_grant;
   logic                  grant_i, grant_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LINE_WIDTH-1:0] wdata_q;

   // last_grant is 1 when D was served last; on contention the other side wins
   always_comb begin
      grant_d = (d_read || d_write) && (!i_read || !last_grant);
      grant_i = i_read && !grant_d;
      state_d = state;
      if (state == IDLE)
         state_d = grant_i ? SERVE_I : grant_d ? (d_write ? SERVE_D_WR : SERVE_D_RD) : IDLE;
      else if (pmem_resp)
         state_d = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state <= state_d;
         if (state == IDLE && (grant_i || grant_d)) begin
            addr_q     <= (grant_i ? i_address : d_address) & ALIGN;
            last_grant <= grant_d;
            if (grant_d && d_write)
               wdata_q <= d_wdata;
         end
      end
   end

   assign pmem_read    = state == SERVE_I || state == SERVE_D_RD;
   assign pmem_write   = state == SERVE_D_WR;
   assign pmem_address = state == IDLE ? '0 : addr_q;
   assign pmem_wdata   = pmem_write ? wdata_q : '0;
   assign i_resp       = state == SERVE_I && pmem_resp;
   assign d_resp       = (state == SERVE_D_RD || state == SERVE_D_WR) && pmem_resp;
   assign i_rdata      = pmem_rdata;
   assign d_rdata      = pmem_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed and randomized checks of cache_arbiter against a
// transaction-level model of who owns the memory port.
module tb_cache_arbiter;
   logic         clk = 1'b0;
   logic         rst;
   logic         i_read, d_read, d_write, pmem_resp;
   logic [31:0]  i_address, d_address;
   logic [255:0] d_wdata, pmem_rdata;
   logic [255:0] i_rdata, d_rdata, pmem_wdata;
   logic         i_resp, d_resp, pmem_read, pmem_write;
   logic [31:0]  pmem_address;

   cache_arbiter dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (!rst) assert (!(d_read && d_write)) else $error("illegal d_read and d_write together");

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] r256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   // stimulus state (what the caches and memory want to drive)
   logic         i_req_r = 0, d_rd_r = 0, d_wr_r = 0, spur = 0, presp;
   logic [31:0]  i_addr_r = 0, d_addr_r = 0;
   logic [255:0] d_wdata_r = 0, rdata_r = 0;
   int           lat_next = 1;
   // model: owner 0 = nobody, 1 = I-cache, 2 = D-cache
   int           owner = 0, cnt = 0;
   logic         last_d = 0, mwr = 0, i_done = 0, d_done = 0;
   logic [31:0]  maddr = 0;
   logic [255:0] mwdata = 0;
   int           grants[$];

   task automatic cycle();
      int win;
      if (i_done) i_req_r = 0;
      if (d_done) begin d_rd_r = 0; d_wr_r = 0; end
      presp = owner != 0 ? cnt == 0 : spur;
      i_read = i_req_r; i_address = i_addr_r;
      d_read = d_rd_r; d_write = d_wr_r; d_address = d_addr_r; d_wdata = d_wdata_r;
      pmem_resp = presp; pmem_rdata = rdata_r;
      #1;
      chk("pmem_read", pmem_read, owner == 1 || (owner == 2 && !mwr));
      chk("pmem_write", pmem_write, owner == 2 && mwr);
      chk("pmem_address", pmem_address, owner != 0 ? maddr : 0);
      chk("pmem_wdata", pmem_wdata, owner == 2 && mwr ? mwdata : 0);
      chk("i_resp", i_resp, owner == 1 && presp);
      chk("d_resp", d_resp, owner == 2 && presp);
      if (owner == 1 && presp) chk("i_rdata", i_rdata, rdata_r);
      if (owner == 2 && presp) chk("d_rdata", d_rdata, rdata_r);
      @(posedge clk);
      i_done = 0; d_done = 0;
      if (owner == 0) begin
         if (i_req_r || d_rd_r || d_wr_r) begin
            win = (i_req_r && (d_rd_r || d_wr_r)) ? (last_d ? 1 : 2) : (i_req_r ? 1 : 2);
            owner = win; last_d = win == 2;
            maddr = (win == 1 ? i_addr_r : d_addr_r) & 32'hFFFF_FFE0;
            mwr = win == 2 && d_wr_r;
            if (mwr) mwdata = d_wdata_r;
            cnt = lat_next;
            grants.push_back(win);
         end
      end else if (presp) begin
         i_done = owner == 1; d_done = owner == 2; owner = 0;
      end else cnt--;
      spur = 0;
      #1;
   endtask

   initial begin
      int ord[4] = '{2, 1, 2, 1};
      rst = 1; i_read = 0; d_read = 0; d_write = 0; i_address = 0; d_address = 0;
      d_wdata = 0; pmem_rdata = 256'hDEAD; pmem_resp = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_read", pmem_read, 0);
      chk("rst_write", pmem_write, 0);
      chk("rst_addr", pmem_address, 0);
      chk("rst_wdata", pmem_wdata, 0);
      chk("rst_i_resp", i_resp, 0);
      chk("rst_d_resp", d_resp, 0);
      chk("rst_i_rdata", i_rdata, 256'hDEAD);
      rst = 0; pmem_resp = 0;

      // lone I miss, memory answers after 3 waiting cycles
      i_req_r = 1; i_addr_r = 32'h0000_1234; lat_next = 3; rdata_r = {32{8'hA5}};
      for (int k = 0; k < 8; k++) cycle();
      // writeback with unaligned address
      d_wr_r = 1; d_addr_r = 32'h8000_003F; d_wdata_r = {64{4'h1}}; lat_next = 2;
      for (int k = 0; k < 7; k++) cycle();
      // spurious memory response while idle
      spur = 1; cycle();
      cycle();

      // reset in the middle of a writeback
      d_wr_r = 1; d_addr_r = 32'h0000_4040; d_wdata_r = r256(); lat_next = 6;
      cycle(); cycle();
      chk("wr_active", pmem_write, 1);
      d_wr_r = 0; d_write = 0; pmem_resp = 1; rst = 1;
      #1;
      chk("arst_write", pmem_write, 0);
      chk("arst_read", pmem_read, 0);
      chk("arst_d_resp", d_resp, 0);
      @(posedge clk); #1;
      rst = 0; owner = 0; last_d = 0; i_done = 0; d_done = 0;
      cycle(); cycle();

      // both held after reset: D, I, D, I
      grants.delete();
      i_addr_r = 32'h0000_0100; d_addr_r = 32'h0000_0200; lat_next = 1;
      for (int k = 0; k < 16; k++) begin
         if (!i_done) i_req_r = 1;
         if (!d_done) d_rd_r = 1;
         rdata_r = r256();
         cycle();
      end
      i_req_r = 0; d_rd_r = 0;
      for (int k = 0; k < 4; k++) chk("order", grants.size() > k ? grants[k] : 0, ord[k]);
      for (int k = 0; k < 4; k++) cycle();

      // back-to-back D reads with I idle
      for (int k = 0; k < 10; k++) begin
         if (!d_done) d_rd_r = 1;
         cycle();
      end
      d_rd_r = 0;
      for (int k = 0; k < 4; k++) cycle();

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         if (!i_req_r && !i_done && $urandom % 4 == 0) begin
            i_req_r = 1; i_addr_r = $urandom;
         end
         if (!d_rd_r && !d_wr_r && !d_done && $urandom % 4 == 0) begin
            if ($urandom % 2) d_wr_r = 1; else d_rd_r = 1;
            d_addr_r = $urandom; d_wdata_r = r256();
         end
         lat_next = $urandom_range(0, 4);
         spur = $urandom % 6 == 0;
         rdata_r = r256();
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
